// File: rtl/tmds_pkg.sv
// Shared TMDS word-aligner definitions: control tokens, FSM states, word width.
// Imported by the run detector and the aligner top.
package tmds_pkg;

  localparam int WORD_BITS = 10;

  localparam logic [WORD_BITS-1:0] CTRL_TOK0 = 10'h354;
  localparam logic [WORD_BITS-1:0] CTRL_TOK1 = 10'h0AB;
  localparam logic [WORD_BITS-1:0] CTRL_TOK2 = 10'h154;
  localparam logic [WORD_BITS-1:0] CTRL_TOK3 = 10'h2AB;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_DELAY_WAIT,
    ST_LOCKED
  } state_e;

  function automatic logic is_ctrl_tok(
    input logic [WORD_BITS-1:0] w
  );
    return (w == CTRL_TOK0) ||
           (w == CTRL_TOK1) ||
           (w == CTRL_TOK2) ||
           (w == CTRL_TOK3);
  endfunction

endpackage

// File: rtl/tmds_ctrl_run_detector.sv
// Counts consecutive TMDS control tokens on the raw word stream.
// run_hit_o fires every cycle the saturating run count sits at CTRL_RUN.
module tmds_ctrl_run_detector
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [WORD_BITS-1:0] data_i,
  output logic                 run_hit_o
);

  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(CTRL_RUN);

  logic          is_ctrl;
  logic [RW-1:0] run_cnt_q;
  logic [RW-1:0] run_cnt_d;

  always_comb begin
    is_ctrl   = is_ctrl_tok(data_i);
    run_cnt_d = '0;
    if (!clear_i && is_ctrl) begin
      if (run_cnt_q == RUN_MAX) begin
        run_cnt_d = run_cnt_q;
      end else begin
        run_cnt_d = run_cnt_q + RW'(1);
      end
    end
  end

  assign run_hit_o = (run_cnt_d == RUN_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS word-boundary aligner driving deserializer bitslip and IDELAY taps.
// Optional TMDS_WORD_ALIGNER_STATS_EN adds slip_total / lock_losses counters.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int WINDOW     = 4096,
  parameter int CTRL_RUN   = 16,
  parameter int SLIP_WAIT  = 4,
  parameter int DELAY_WAIT = 16,
  parameter int DELAY_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] data_in,
  output logic                 bitslip,
  output logic [4:0]           delay,
  output logic                 load_delay,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 aligned
`ifdef TMDS_WORD_ALIGNER_STATS_EN
  ,
  output logic [15:0]          slip_total,
  output logic [7:0]           lock_losses
`endif
);

  localparam int WW   = $clog2(WINDOW);
  localparam int WMAX = (SLIP_WAIT > DELAY_WAIT) ?
                        SLIP_WAIT : DELAY_WAIT;
  localparam int TW   = $clog2(WMAX + 1);

  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [TW-1:0] SLIP_END = TW'(SLIP_WAIT);
  localparam logic [TW-1:0] DLY_END  = TW'(DELAY_WAIT);
  localparam logic [4:0]    DLY_INC  = 5'(DELAY_STEP);

  state_e              state_q;
  logic [WW-1:0]       win_q;
  logic [TW-1:0]       wait_q;
  logic [3:0]          slip_q;
  logic [4:0]          delay_q;
  logic                bitslip_q;
  logic                load_q;
  logic                aligned_q;
  logic [WORD_BITS-1:0] data_q;
`ifdef TMDS_WORD_ALIGNER_STATS_EN
  logic [15:0]         slip_tot_q;
  logic [7:0]          loss_q;
`endif

  logic run_hit;
  logic run_clr;
  logic win_done;

  assign run_clr  = (state_q != ST_SEARCH) &&
                    (state_q != ST_LOCKED);
  assign win_done = (win_q == WIN_LAST);

  tmds_ctrl_run_detector #(
    .CTRL_RUN (CTRL_RUN)
  ) u_run (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (run_clr),
    .data_i    (data_in),
    .run_hit_o (run_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      win_q      <= '0;
      wait_q     <= '0;
      slip_q     <= '0;
      delay_q    <= '0;
      bitslip_q  <= 1'b0;
      load_q     <= 1'b0;
      aligned_q  <= 1'b0;
      data_q     <= '0;
`ifdef TMDS_WORD_ALIGNER_STATS_EN
      slip_tot_q <= '0;
      loss_q     <= '0;
`endif
    end else begin
      bitslip_q <= 1'b0;
      load_q    <= 1'b0;
      data_q    <= data_in;
      unique case (state_q)
        ST_INIT: begin
          delay_q <= '0;
          load_q  <= 1'b1;
          wait_q  <= '0;
          win_q   <= '0;
          state_q <= ST_DELAY_WAIT;
        end
        ST_SEARCH: begin
          win_q <= win_q + WW'(1);
          // A lock on the window's last cycle takes priority over a slip
          if (run_hit) begin
            win_q     <= '0;
            aligned_q <= 1'b1;
            state_q   <= ST_LOCKED;
          end else if (win_done) begin
            win_q  <= '0;
            wait_q <= '0;
            if (slip_q != 4'd9) begin
              slip_q    <= slip_q + 4'd1;
              bitslip_q <= 1'b1;
              state_q   <= ST_SLIP_WAIT;
`ifdef TMDS_WORD_ALIGNER_STATS_EN
              if (slip_tot_q != 16'hFFFF) begin
                slip_tot_q <= slip_tot_q + 16'd1;
              end
`endif
            end else begin
              slip_q  <= '0;
              delay_q <= delay_q + DLY_INC;
              load_q  <= 1'b1;
              state_q <= ST_DELAY_WAIT;
            end
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_q == SLIP_END) begin
            win_q   <= '0;
            state_q <= ST_SEARCH;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        ST_DELAY_WAIT: begin
          if (wait_q == DLY_END) begin
            win_q   <= '0;
            state_q <= ST_SEARCH;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        ST_LOCKED: begin
          win_q <= win_q + WW'(1);
          if (run_hit) begin
            win_q <= '0;
          end else if (win_done) begin
            // Keep slip/delay so the search resumes from here
            win_q     <= '0;
            aligned_q <= 1'b0;
            state_q   <= ST_SEARCH;
`ifdef TMDS_WORD_ALIGNER_STATS_EN
            if (loss_q != 8'hFF) begin
              loss_q <= loss_q + 8'd1;
            end
`endif
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign bitslip    = bitslip_q;
  assign load_delay = load_q;
  assign delay      = delay_q;
  assign aligned    = aligned_q;
  assign data_out   = data_q;
`ifdef TMDS_WORD_ALIGNER_STATS_EN
  assign slip_total  = slip_tot_q;
  assign lock_losses = loss_q;
`endif

endmodule
